sw_alloc: RTL

SW_ALLOC -- requirements
Module: sw_alloc

---
 rtl/sw_alloc.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sw_alloc.sv
// Switch allocator: one IDLE/LOCKED FSM per output port with round-robin input selection.
// Optional watchdog force-release is compiled in with SA_WATCHDOG_EN.
module sw_alloc #(
  parameter int NPORT    = 5,
  parameter int PW       = 3,
  parameter int WD_LIMIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_0,
  input  logic             req_1,
  input  logic             req_2,
  input  logic             req_3,
  input  logic             req_4,
  input  logic [PW-1:0]    port_0,
  input  logic [PW-1:0]    port_1,
  input  logic [PW-1:0]    port_2,
  input  logic [PW-1:0]    port_3,
  input  logic [PW-1:0]    port_4,
  input  logic             ivalid_0,
  input  logic             ivalid_1,
  input  logic             ivalid_2,
  input  logic             ivalid_3,
  input  logic             ivalid_4,
  input  logic             tail_0,
  input  logic             tail_1,
  input  logic             tail_2,
  input  logic             tail_3,
  input  logic             tail_4,
  input  logic [NPORT-1:0] avail,
  output logic [NPORT-1:0] grt_0,
  output logic [NPORT-1:0] grt_1,
  output logic [NPORT-1:0] grt_2,
  output logic [NPORT-1:0] grt_3,
  output logic [NPORT-1:0] grt_4,
  output logic [NPORT-1:0] busy,
  output logic             wd_err
);
  typedef enum logic {IDLE, LOCKED} st_e;

  logic [NPORT-1:0]               req, ivalid, tail;
  logic [NPORT-1:0][PW-1:0]       port;
  st_e                            st_q [NPORT];
  logic [NPORT-1:0][PW-1:0]       own_q, rr_q;
  logic [NPORT-1:0]               locked, granted, taken, win, rel, wd_fire;
  logic [NPORT-1:0][PW-1:0]       win_idx;
  logic [NPORT-1:0][NPORT-1:0]    grt;
  logic                           found;
  logic [PW-1:0]                  sel;
  int                             idx;

  assign req    = {req_4, req_3, req_2, req_1, req_0};
  assign ivalid = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
  assign tail   = {tail_4, tail_3, tail_2, tail_1, tail_0};
  assign port   = {port_4, port_3, port_2, port_1, port_0};

  // Grants come straight from registered lock state, so reset clears them asynchronously.
  always_comb begin
    grt     = '0;
    granted = '0;
    for (int o = 0; o < NPORT; o++) begin
      locked[o] = (st_q[o] == LOCKED);
      for (int i = 0; i < NPORT; i++)
        grt[i][o] = locked[o] && (own_q[o] == PW'(i));
    end
    for (int i = 0; i < NPORT; i++) granted[i] = |grt[i];
  end

  assign busy  = locked;
  assign grt_0 = grt[0];
  assign grt_1 = grt[1];
  assign grt_2 = grt[2];
  assign grt_3 = grt[3];
  assign grt_4 = grt[4];

  // Port codes >= NPORT never match any output index, so they are ignored for free.
  always_comb begin
    win     = '0;
    win_idx = '0;
    taken   = '0;
    found   = 1'b0;
    sel     = '0;
    idx     = 0;
    for (int o = 0; o < NPORT; o++) begin
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < NPORT; k++) begin
        idx = (int'(rr_q[o]) + k) % NPORT;
        if (!found && req[idx] && port[idx] == PW'(o) && !granted[idx]) begin
          found = 1'b1;
          sel   = PW'(idx);
        end
      end
      // A lower output that already claimed this input wins; this output stays idle.
      if (!locked[o] && avail[o] && found && !taken[sel]) begin
        win[o]     = 1'b1;
        win_idx[o] = sel;
        taken[sel] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NPORT; o++)
      rel[o] = locked[o] && ((ivalid[own_q[o]] && tail[own_q[o]]) || !req[own_q[o]] || wd_fire[o]);
  end

`ifdef SA_WATCHDOG_EN
  localparam int CW = $clog2(WD_LIMIT + 1);
  logic [NPORT-1:0][CW-1:0] wd_cnt_q;
  logic                     wd_err_q;

  always_comb begin
    for (int o = 0; o < NPORT; o++)
      wd_fire[o] = locked[o] && !ivalid[own_q[o]] && (wd_cnt_q[o] == CW'(WD_LIMIT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (!locked[o] || rel[o] || ivalid[own_q[o]]) wd_cnt_q[o] <= '0;
        else                                          wd_cnt_q[o] <= wd_cnt_q[o] + 1'b1;
      end
      wd_err_q <= |wd_fire;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_fire = '0;
  assign wd_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int o = 0; o < NPORT; o++) st_q[o] <= IDLE;
      own_q <= '0;
      rr_q  <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        case (st_q[o])
          IDLE: if (win[o]) begin
            st_q[o]  <= LOCKED;
            own_q[o] <= win_idx[o];
          end
          LOCKED: if (rel[o]) begin
            st_q[o] <= IDLE;
            rr_q[o] <= (own_q[o] == PW'(NPORT - 1)) ? '0 : own_q[o] + 1'b1;
          end
          default: st_q[o] <= IDLE;
        endcase
      end
    end
  end
endmodule
